vga_sync_gen: RTL

Generates 640x480 @ 60 Hz VGA timing from the 50 MHz board clock. It produces the pixel clock for the video DAC, horizontal and vertical sync, the blanking flag, and the current pixel coordinates `x`/`y`. It sits directly upstream of every screen renderer (win screens, board drawing, menus). Those renderers are pure combinational functions of `x`/`y`; this block is the only sequential timing source in the video path.

---
 rtl/vga_sync_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// Purpose:
//   Produces VGA raster timing (640x480 @ 60 Hz with the default parameters)
//   from the 50 MHz board clock. A divide-by-2 toggle provides both the 25 MHz
//   pixel clock for the DAC and a one-clk-wide pixel enable. Horizontal and
//   vertical counters walk the full raster; x/y, the sync pulses and the
//   blanking flag are registered copies decoded from the counters, so every
//   downstream renderer sees mutually aligned, glitch-free values.
//
// Ports:
//   clk          in   50 MHz system clock (only clock domain)
//   rst          in   synchronous, active-high reset
//   vga_clk      out  25 MHz pixel clock (registered toggle)
//   pix_tick     out  one-clk-wide pixel-advance enable (same toggle)
//   x [9:0]      out  current pixel column, 0..H_TOTAL-1
//   y [9:0]      out  current line, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   video_on     out  high inside the visible area, doubles as DAC blank_n
//   sync_n       out  constant 0 (no sync-on-green)
//   frame_start  out  one-clk pulse when the outputs enter (0,0)
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       vga_clk,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       sync_n,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All decode boundaries are kept as inclusive "last" values so that a
    // raster using the full 1024-entry range never needs an 11-bit constant.
    localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_LAST    = 10'(V_ACTIVE - 1);
    localparam logic [9:0] H_SYNC_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic       toggle_q,     toggle_d;
    logic [9:0] hCnt_q,       hCnt_d;
    logic [9:0] vCnt_q,       vCnt_d;
    logic [9:0] x_q,          x_d;
    logic [9:0] y_q,          y_d;
    logic       hsync_q,      hsync_d;
    logic       vsync_q,      vsync_d;
    logic       videoOn_q,    videoOn_d;
    logic       frameStart_q, frameStart_d;

    logic       hWrap;
    logic       vWrap;
    logic       hInSync;
    logic       vInSync;
    logic       hVisible;
    logic       vVisible;

    // Counter wrap detection. The wrap is taken on equality with the last
    // count so the increment never has to represent H_TOTAL/V_TOTAL itself.
    always_comb begin
        hWrap = (hCnt_q == H_LAST);
        vWrap = (vCnt_q == V_LAST);
    end

    // Next-state for the toggle and the raster counters. The toggle flips on
    // every clk; the counters only move on edges where the toggle is high,
    // i.e. once per pixel period. vcnt only moves when the line wraps.
    always_comb begin
        toggle_d = ~toggle_q;
        hCnt_d   = hCnt_q;
        vCnt_d   = vCnt_q;
        if (toggle_q) begin
            if (hWrap) begin
                hCnt_d = '0;
                if (vWrap) begin
                    vCnt_d = '0;
                end else begin
                    vCnt_d = vCnt_q + 10'd1;
                end
            end else begin
                hCnt_d = hCnt_q + 10'd1;
            end
        end
    end

    // Region decode from the pre-increment counters. Registering these on
    // the tick is what makes the outputs lag the counters by exactly one
    // pixel while staying aligned with each other.
    always_comb begin
        hInSync  = (hCnt_q >= H_SYNC_FIRST) && (hCnt_q <= H_SYNC_LAST);
        vInSync  = (vCnt_q >= V_SYNC_FIRST) && (vCnt_q <= V_SYNC_LAST);
        hVisible = (hCnt_q <= H_ACT_LAST);
        vVisible = (vCnt_q <= V_ACT_LAST);
    end

    // Output next-state: x/y/syncs/blank only reload on a tick and otherwise
    // hold, giving each value a full two-clk pixel period. The frame pulse is
    // recomputed every clk so it is high for just the one cycle following
    // the tick that loads the origin.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        videoOn_d    = videoOn_q;
        frameStart_d = toggle_q && (hCnt_q == 10'd0) && (vCnt_q == 10'd0);
        if (toggle_q) begin
            x_d       = hCnt_q;
            y_d       = vCnt_q;
            hsync_d   = ~hInSync;
            vsync_d   = ~vInSync;
            videoOn_d = hVisible && vVisible;
        end
    end

    // State register. Reset takes priority over ticking so any sync pulse in
    // progress is cut off on the very edge that samples reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q     <= 1'b0;
            hCnt_q       <= '0;
            vCnt_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            videoOn_q    <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            toggle_q     <= toggle_d;
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            videoOn_q    <= videoOn_d;
            frameStart_q <= frameStart_d;
        end
    end

    // The pixel clock and the pixel enable are the same register: the
    // renderers use the enable inside the clk domain, the DAC gets the clock.
    always_comb begin
        vga_clk     = toggle_q;
        pix_tick    = toggle_q;
        x           = x_q;
        y           = y_q;
        hsync       = hsync_q;
        vsync       = vsync_q;
        video_on    = videoOn_q;
        sync_n      = 1'b0;
        frame_start = frameStart_q;
    end

endmodule
